adc_frame_unpacker: RTL and testbench
=====================================

Name: adc_frame_unpacker

Overview:
- Sits directly downstream of the ADC SPI interface; consumes its 128-bit `serial_read` frame.
- Splits each frame into eight 16-bit channel samples and streams them one per handshake over a valid/ready interface.
- Double-buffers frames, so a new frame can arrive while the previous one is still draining.
- Counts accepted frames and flags dropped ones.

Parameters:
- FRAME_W, 128, width of the frame from the SPI interface.
- SAMPLE_W, 16, bits per channel sample; NUM_CH = FRAME_W/SAMPLE_W = 8 (derived, not overridable).
- CNT_W, 16, width of the accepted-frame counter.

Ports:
- SCLK  in  1  system clock, all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FRAME_IN  in  FRAME_W  completed frame from the SPI interface.
- FRAME_VALID  in  1  single-cycle strobe; FRAME_IN is valid in that cycle only.
- SAMPLE_OUT  out  SAMPLE_W  current channel sample.
- CH_ID  out  3  channel index of SAMPLE_OUT, 0..7.
- SAMPLE_VALID  out  1  SAMPLE_OUT/CH_ID are valid.
- SAMPLE_READY  in  1  downstream accepts the sample.
- LAST  out  1  high with SAMPLE_VALID when CH_ID==7.
- BUSY  out  1  active frame register occupied.
- OVERFLOW  out  1  sticky: a frame was dropped.
- OVF_CLR  in  1  clears OVERFLOW.
- FRAME_CNT  out  CNT_W  frames accepted (not dropped), wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync-released use) clears all outputs:
  - SAMPLE_OUT=0, CH_ID=0, SAMPLE_VALID=0, LAST=0, BUSY=0, OVERFLOW=0, FRAME_CNT=0.
  - Both buffers are marked empty and the FSM goes to IDLE.
- Channel mapping (the frame is shifted MSB-first):
  - Channel k = FRAME_IN[FRAME_W-1-k*SAMPLE_W -: SAMPLE_W].
  - Channel 0 = bits [127:112]; channel 7 = bits [15:0].
  - No sign extension or reordering.
- Storage: ACTIVE register (draining) plus PENDING register (one-frame skid), each with its own valid bit.
- FSM states: IDLE, STREAM.
- IDLE:
  - On FRAME_VALID, FRAME_IN goes to ACTIVE, CH_ID=0, FRAME_CNT increments, next state STREAM.
  - SAMPLE_VALID=1 in the next cycle (latency 1 clock).
- STREAM:
  - SAMPLE_VALID=1 and BUSY=1.
  - On SAMPLE_VALID&&SAMPLE_READY with CH_ID<7: CH_ID increments.
  - SAMPLE_OUT/CH_ID stay stable while SAMPLE_VALID && !SAMPLE_READY.
- Transfer of channel 7 (LAST handshake) takes the first matching case:
  - PENDING valid: PENDING moves to ACTIVE, CH_ID=0, stay in STREAM with no bubble. Priority goes to the older frame.
  - Else FRAME_VALID in the same cycle: FRAME_IN goes to ACTIVE, CH_ID=0, stay in STREAM with no bubble.
  - Else: go to IDLE; SAMPLE_VALID=0 and BUSY=0 next cycle.
- FRAME_VALID while in STREAM:
  - PENDING empty, or PENDING being moved to ACTIVE this cycle: FRAME_IN is written to PENDING.
  - PENDING full and not draining this cycle: frame dropped, OVERFLOW=1, FRAME_CNT unchanged.
- FRAME_CNT increments once per accepted frame, whether it lands in ACTIVE or PENDING.
- OVERFLOW:
  - Sticky until OVF_CLR.
  - If OVF_CLR and a new drop happen in the same cycle, set wins.
- FRAME_VALID held high for several cycles is treated as several frames; the upstream interface guarantees single-cycle strobes.
- Reset mid-stream discards ACTIVE and PENDING immediately; no sample is emitted after RST_N falls.
- Throughput: 1 sample/clock with SAMPLE_READY tied high, so one frame drains in 8 clocks.
- SAMPLE_VALID never drops between back-to-back frames.

Test Plan:
- Single frame, FRAME_IN=128'h0000_1111_2222_3333_4444_5555_6666_7777, READY=1:
  - SAMPLE_OUT sequence 0000..7777 with CH_ID 0..7 on consecutive clocks starting 1 clock after FRAME_VALID.
  - LAST on the 8th sample; FRAME_CNT=1; BUSY low afterwards.
- Backpressure: READY toggled 1,0,0,1,... during a frame:
  - SAMPLE_OUT/CH_ID held constant through the low cycles.
  - All 8 samples delivered exactly once, in order.
- Back-to-back frames A and B, B strobed at channel 3 of A:
  - A ch7 is followed immediately by B ch0 (SAMPLE_VALID never deasserts); FRAME_CNT=2.
- Overflow: READY=0, three FRAME_VALID strobes:
  - Third frame dropped: OVERFLOW=1, FRAME_CNT=2.
  - Releasing READY yields 16 samples (first two frames only).
  - OVF_CLR pulse clears OVERFLOW.
- Simultaneous: FRAME_VALID in the same cycle as the LAST handshake with PENDING empty:
  - New frame ch0 is emitted the next clock with no bubble.
- Reset mid-stream: RST_N low at ch4:
  - All outputs 0 asynchronously, FRAME_CNT=0.
  - After release, a fresh frame starts at CH_ID=0.
- Randomized: a $urandom bitstream is packed into frames, compared against a bench scoreboard, with random READY.

Source files
------------

// File: rtl/adc_frame_unpacker.sv
// -----------------------------------------------------------------------------
// adc_frame_unpacker
//
// Splits 128-bit frames from the ADC SPI interface into eight 16-bit channel
// samples and streams them one per valid/ready handshake. An ACTIVE register
// drains the current frame while a PENDING register holds one further frame,
// so a new frame may arrive while the previous one is still draining. Frames
// that find both registers occupied are dropped and flagged.
//
// Ports:
//   SCLK          system clock, rising edge
//   RST_N         asynchronous active-low reset
//   FRAME_IN      completed frame, valid only while FRAME_VALID is high
//   FRAME_VALID   single-cycle frame strobe
//   SAMPLE_OUT    current channel sample (channel 0 = FRAME_IN MSBs)
//   CH_ID         channel index of SAMPLE_OUT
//   SAMPLE_VALID  SAMPLE_OUT/CH_ID valid
//   SAMPLE_READY  downstream accepts the sample
//   LAST          SAMPLE_VALID with CH_ID == 7
//   BUSY          ACTIVE register occupied
//   OVERFLOW      sticky dropped-frame flag
//   OVF_CLR       clears OVERFLOW (a simultaneous drop wins)
//   FRAME_CNT     accepted frames, wraps
// -----------------------------------------------------------------------------
module adc_frame_unpacker #(
  parameter int FRAME_W  = 128,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                SCLK,
  input  logic                RST_N,
  input  logic [FRAME_W-1:0]  FRAME_IN,
  input  logic                FRAME_VALID,
  output logic [SAMPLE_W-1:0] SAMPLE_OUT,
  output logic [2:0]          CH_ID,
  output logic                SAMPLE_VALID,
  input  logic                SAMPLE_READY,
  output logic                LAST,
  output logic                BUSY,
  output logic                OVERFLOW,
  input  logic                OVF_CLR,
  output logic [CNT_W-1:0]    FRAME_CNT
);

  localparam int NUM_CH = FRAME_W / SAMPLE_W;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Channel k sits at the top of the frame for k = 0 (frame is shifted MSB-first).
  function automatic logic [SAMPLE_W-1:0] channel_of(input logic [FRAME_W-1:0] frame,
                                                     input logic [2:0]         ch);
    channel_of = frame[FRAME_W-1-(int'(ch)*SAMPLE_W) -: SAMPLE_W];
  endfunction

  logic [0:0]          state_q,    state_d;
  logic [FRAME_W-1:0]  active_q,   active_d;
  logic [FRAME_W-1:0]  pend_q,     pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [2:0]          ch_q,       ch_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                ovf_q,      ovf_d;
  logic [SAMPLE_W-1:0] sample_q,   sample_d;
  logic                valid_q,    valid_d;
  logic                last_q,     last_d;

  logic hs_s;
  logic last_hs_s;
  logic accept_s;
  logic drop_s;

  // Next-state logic: handshake, frame routing into ACTIVE/PENDING, drop detection.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    accept_s   = 1'b0;
    drop_s     = 1'b0;

    hs_s      = (state_q == ST_STREAM) && SAMPLE_READY;
    last_hs_s = hs_s && (ch_q == LAST_CH);

    case (state_q)
      ST_IDLE: begin
        if (FRAME_VALID) begin
          active_d = FRAME_IN;
          ch_d     = 3'd0;
          state_d  = ST_STREAM;
          accept_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        // Drain side: advance the channel, or refill ACTIVE on the last handshake.
        // The older (pending) frame takes priority over a frame arriving now.
        if (hs_s) begin
          if (ch_q != LAST_CH) begin
            ch_d = ch_q + 3'd1;
          end else if (pend_vld_q) begin
            active_d   = pend_q;
            ch_d       = 3'd0;
            pend_vld_d = 1'b0;
          end else if (FRAME_VALID) begin
            active_d = FRAME_IN;
            ch_d     = 3'd0;
            accept_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ch_d = ch_q;
        end

        // Fill side: PENDING accepts a frame if empty, or if it is emptying
        // into ACTIVE this very cycle. A frame going straight into ACTIVE
        // was already handled above.
        if (FRAME_VALID) begin
          if (pend_vld_q && !last_hs_s) begin
            drop_s = 1'b1;
          end else if (!(last_hs_s && !pend_vld_q)) begin
            pend_d     = FRAME_IN;
            pend_vld_d = 1'b1;
            accept_s   = 1'b1;
          end else begin
            pend_vld_d = 1'b0;
          end
        end else begin
          drop_s = 1'b0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        pend_vld_d = 1'b0;
        ch_d       = 3'd0;
      end
    endcase

    // Drop sets the sticky flag even when a clear arrives in the same cycle.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (accept_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end

    // Output registers are loaded from next-state values so the sample shows
    // one clock after the frame strobe and never bubbles between frames.
    valid_d  = (state_d == ST_STREAM);
    sample_d = channel_of(active_d, ch_d);
    last_d   = valid_d && (ch_d == LAST_CH);
  end

  // State and output registers; reset discards both frame buffers immediately.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      active_q   <= {FRAME_W{1'b0}};
      pend_q     <= {FRAME_W{1'b0}};
      pend_vld_q <= 1'b0;
      ch_q       <= 3'd0;
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      sample_q   <= {SAMPLE_W{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign SAMPLE_OUT   = sample_q;
  assign CH_ID        = ch_q;
  assign SAMPLE_VALID = valid_q;
  assign LAST         = last_q;
  assign BUSY         = valid_q;
  assign OVERFLOW     = ovf_q;
  assign FRAME_CNT    = cnt_q;

endmodule

// File: tb/tb_adc_frame_unpacker.sv
// -----------------------------------------------------------------------------
// Testbench for adc_frame_unpacker. A reference model holds accepted frames in
// a queue of at most two entries and an index into the head frame; every cycle
// the DUT outputs are compared against what the model says should be visible.
// -----------------------------------------------------------------------------
module tb_adc_frame_unpacker;

  logic         SCLK;
  logic         RST_N;
  logic [127:0] FRAME_IN;
  logic         FRAME_VALID;
  logic [15:0]  SAMPLE_OUT;
  logic [2:0]   CH_ID;
  logic         SAMPLE_VALID;
  logic         SAMPLE_READY;
  logic         LAST;
  logic         BUSY;
  logic         OVERFLOW;
  logic         OVF_CLR;
  logic [15:0]  FRAME_CNT;

  adc_frame_unpacker dut (
    .SCLK         (SCLK),
    .RST_N        (RST_N),
    .FRAME_IN     (FRAME_IN),
    .FRAME_VALID  (FRAME_VALID),
    .SAMPLE_OUT   (SAMPLE_OUT),
    .CH_ID        (CH_ID),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .LAST         (LAST),
    .BUSY         (BUSY),
    .OVERFLOW     (OVERFLOW),
    .OVF_CLR      (OVF_CLR),
    .FRAME_CNT    (FRAME_CNT)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  // Reference model state
  logic [127:0] fq[$];
  int           idx;
  logic [15:0]  m_cnt;
  logic         m_ovf;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_sample(input logic [127:0] f, input int k);
    logic [127:0] t;
    t = f >> (112 - 16 * k);
    return t[15:0];
  endfunction

  function automatic logic [127:0] rand_frame();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    fq.delete();
    idx   = 0;
    m_cnt = 16'd0;
    m_ovf = 1'b0;
  endtask

  // One clock: check what is visible now, then drive inputs and advance the model.
  task automatic step(input logic fv, input logic [127:0] fin, input logic rdy, input logic clr);
    logic exp_v;
    logic drop;
    @(negedge SCLK);
    exp_v = (fq.size() != 0);
    chk("valid", 128'(SAMPLE_VALID), 128'(exp_v));
    chk("busy", 128'(BUSY), 128'(exp_v));
    if (exp_v) begin
      chk("sample", 128'(SAMPLE_OUT), 128'(exp_sample(fq[0], idx)));
      chk("ch_id", 128'(CH_ID), 128'(idx));
      chk("last", 128'(LAST), 128'(idx == 7));
    end else begin
      chk("last_idle", 128'(LAST), 128'(1'b0));
    end
    chk("overflow", 128'(OVERFLOW), 128'(m_ovf));
    chk("frame_cnt", 128'(FRAME_CNT), 128'(m_cnt));

    FRAME_VALID  = fv;
    FRAME_IN     = fin;
    SAMPLE_READY = rdy;
    OVF_CLR      = clr;

    if (exp_v && rdy) begin
      idx++;
      if (idx == 8) begin
        fq.delete(0);
        idx = 0;
      end
    end
    drop = 1'b0;
    if (fv) begin
      if (fq.size() < 2) begin
        fq.push_back(fin);
        m_cnt++;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 128'd0, rdy, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sample"}, 128'(SAMPLE_OUT), 128'd0);
    chk({tag, "_ch"}, 128'(CH_ID), 128'd0);
    chk({tag, "_valid"}, 128'(SAMPLE_VALID), 128'd0);
    chk({tag, "_last"}, 128'(LAST), 128'd0);
    chk({tag, "_busy"}, 128'(BUSY), 128'd0);
    chk({tag, "_ovf"}, 128'(OVERFLOW), 128'd0);
    chk({tag, "_cnt"}, 128'(FRAME_CNT), 128'd0);
  endtask

  initial begin
    logic [127:0] fa;
    logic [127:0] fb;
    n_vec = 0;
    n_err = 0;
    RST_N        = 1'b0;
    FRAME_IN     = 128'd0;
    FRAME_VALID  = 1'b0;
    SAMPLE_READY = 1'b0;
    OVF_CLR      = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(negedge SCLK);
    check_zero_outputs("reset");
    RST_N = 1'b1;
    idle(2, 1'b1);

    // Single frame, ready held high
    step(1'b1, 128'h0000_1111_2222_3333_4444_5555_6666_7777, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Backpressure with ready pattern 1,0,0,1
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 128'd0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
    idle(4, 1'b1);

    // Back-to-back: B strobed while A shows channel 3
    fa = rand_frame();
    fb = rand_frame();
    step(1'b1, fa, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, fb, 1'b1, 1'b0);
    idle(14, 1'b1);

    // Overflow: three strobes with ready low, third dropped
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(18, 1'b1);
    step(1'b0, 128'd0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // New frame in the same cycle as the last handshake, pending empty
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    idle(7, 1'b1);
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    idle(10, 1'b1);

    // Drop coinciding with OVF_CLR: set wins
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    step(1'b1, rand_frame(), 1'b0, 1'b0);
    step(1'b1, rand_frame(), 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(18, 1'b1);
    step(1'b0, 128'd0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset mid-stream while channel 4 is shown, asserted away from a clock edge
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    idle(3, 1'b1);
    @(negedge SCLK);
    chk("pre_reset_ch", 128'(CH_ID), 128'd4);
    RST_N        = 1'b0;
    FRAME_VALID  = 1'b0;
    SAMPLE_READY = 1'b0;
    OVF_CLR      = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_clear();
    repeat (2) @(negedge SCLK);
    check_zero_outputs("held_reset");
    RST_N = 1'b1;
    step(1'b1, rand_frame(), 1'b1, 1'b0);
    idle(10, 1'b1);

    // Randomized frames and ready
    for (int i = 0; i < 600; i++) begin
      step(($urandom() % 4) == 0, rand_frame(), ($urandom() % 3) != 0, ($urandom() % 16) == 0);
    end
    idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
